key_action_ctrl: RTL and testbench
==================================

// Module: key_action_ctrl
// PURPOSE
//  Turns the packed USB HID keycode slots from the MicroBlaze GPIO into per-action game commands.
//  It replaces raw keycode[7:0] compares inside the game logic.
//  - Maps N keycode slots onto NUM_ACTIONS actions.
//  - Per action: press edge, release edge, and auto-repeat (DAS delay, then ARR period).
//  - Advances once per frame_tick, so outputs line up with the game's frame-rate logic.
//  - Sits between mb_block keycode GPIO and the game block (left/right/soft-drop/rotate/pause).
// PARAMETERS
//  NUM_SLOTS    8                  keycode slots in; {keycode1,keycode0} = 8 bytes
//  NUM_ACTIONS  6                  number of actions
//  ACTION_CODES {13,14,1A,16,07,04}h  packed; action i = bits[8i+7:8i]; 8'h00 disables action i
//  REPEAT_MASK  6'b000111          bit i=1: action i auto-repeats; bit i=0: fires once per press
//  DAS_FRAMES   10                 frames from first fire to first repeat fire; >=1
//  ARR_FRAMES   2                  frames between repeat fires; >=1
//  CNT_W        5                  counter width; must hold max(DAS_FRAMES,ARR_FRAMES)-1
// PORTS
//  clk            in   1            system clock; keycodes already in this domain
//  reset          in   1            async, active-high
//  frame_tick     in   1            one-clk pulse per frame (vsync rising edge)
//  keycodes       in   NUM_SLOTS*8  slot s = bits[8s+7:8s]
//  action_fire    out  NUM_ACTIONS  1-clk pulse: press or repeat fire
//  action_press   out  NUM_ACTIONS  1-clk pulse: press edge only
//  action_release out  NUM_ACTIONS  1-clk pulse: release edge
//  action_held    out  NUM_ACTIONS  level: action state != IDLE
//  rollover_err   out  1            level: last sampled frame had an 8'h01 slot
// BEHAVIOUR
//  Matching
//  - pressed[i] = ACTION_CODES[i]!=0 and any slot == ACTION_CODES[i].
//  - 8'h00 never matches. A code repeated across slots counts as one press.
//  Sampling and latency
//  - keycodes are sampled only on cycles with frame_tick=1.
//  - Pulse outputs are registered: asserted exactly 1 clk, the cycle after the tick. Latency = 1 clk.
//  - All pulses are 0 on non-tick+1 cycles.
//  Rollover error (any slot == 8'h01 at a tick)
//  - No state or counter changes, no pulses that frame.
//  - rollover_err=1 until the next clean tick.
//  Per-action FSM, evaluated only at ticks; cnt is CNT_W bits
//  - IDLE:
//    - pressed -> fire+press.
//    - REPEAT_MASK[i]=1: go DELAY with cnt=DAS_FRAMES-1.
//    - REPEAT_MASK[i]=0: go HELD.
//  - DELAY:
//    - !pressed -> release, go IDLE.
//    - cnt==0 -> fire, go REPEAT with cnt=ARR_FRAMES-1.
//    - otherwise cnt-1.
//  - REPEAT:
//    - !pressed -> release, go IDLE.
//    - cnt==0 -> fire, cnt=ARR_FRAMES-1.
//    - otherwise cnt-1.
//  - HELD: !pressed -> release, go IDLE.
//  - ARR_FRAMES=1 gives a fire every tick in REPEAT.
//  Independence and simultaneous events
//  - Actions are fully independent.
//  - Simultaneous presses, e.g. left+right, fire both; arbitration belongs to the game block.
//  - Release and re-press between two ticks is invisible; the action stays held.
//  Reset (also mid-operation)
//  - All FSMs go IDLE, cnt=0, every output 0.
//  - A key still down after reset is treated as a new press at the next tick.
// STRUCTURE
//  - Package key_action_pkg:
//    - action index constants ACT_LEFT=0, ACT_RIGHT, ACT_DOWN, ACT_ROT_CW, ACT_ROT_CCW, ACT_PAUSE.
//    - HID code constants KEY_A=8'h04, KEY_D=8'h07, KEY_S=8'h16, KEY_W=8'h1A,
//      KEY_Q=8'h14, KEY_P=8'h13, KEY_ROLLOVER=8'h01.
//    - fsm enum {IDLE, DELAY, REPEAT, HELD}.
//  - Top: slot compare and rollover detect, both combinational.
//  - Sub-module key_repeat_fsm: one FSM plus counter, instantiated NUM_ACTIONS times by generate.
//    Parameters REPEAT, DAS_FRAMES, ARR_FRAMES, CNT_W.
// TESTING
//  Bench uses defaults and ticks every 4 clks.
//  1. Hold 8'h04 in slot 0 for 20 ticks.
//     -> fire[0] after ticks 0,10,12,14,16,18; press[0] once; held[0]=1 throughout.
//  2. Hold 8'h1A for 20 ticks, then release.
//     -> fire[3] once only, at tick 0; release[3] pulses 1 clk after the release tick.
//  3. Slot 0=8'h04, slot 5=8'h07, pressed at the same tick.
//     -> fire[0] and fire[1] pulse in the same clk.
//     -> 8'h04 in two slots behaves like one key.
//  4. Hold 8'h07; at tick 5 put 8'h01 in slot 7 for 3 ticks.
//     -> no pulses, rollover_err=1 for those ticks.
//     -> first repeat fire moves from tick 10 to tick 13.
//  5. Hold 8'h16; assert reset at tick 6 for 3 clks.
//     -> all outputs 0 at once; fresh press at the next tick after reset; DAS restarts from there.
//  6. Keycode change between ticks, with frame_tick held low.
//     -> no output activity; all-zero keycodes ignored.

Source files
------------

// File: rtl/key_action_pkg.sv
// Shared action indices, HID key codes and repeat-FSM states
// for the keyboard action controller.
package key_action_pkg;

  localparam int ACT_LEFT    = 0;
  localparam int ACT_RIGHT   = 1;
  localparam int ACT_DOWN    = 2;
  localparam int ACT_ROT_CW  = 3;
  localparam int ACT_ROT_CCW = 4;
  localparam int ACT_PAUSE   = 5;

  localparam logic [7:0] KEY_A        = 8'h04;
  localparam logic [7:0] KEY_D        = 8'h07;
  localparam logic [7:0] KEY_S        = 8'h16;
  localparam logic [7:0] KEY_W        = 8'h1A;
  localparam logic [7:0] KEY_Q        = 8'h14;
  localparam logic [7:0] KEY_P        = 8'h13;
  localparam logic [7:0] KEY_ROLLOVER = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT,
    HELD
  } rpt_state_e;

endpackage

// File: rtl/key_action_ctrl_fsm.sv
// Per-action repeat FSM: press, release and DAS/ARR auto-repeat
// pulses, advanced only on qualified frame ticks.
module key_repeat_fsm #(
  parameter bit REPEAT     = 1'b1,
  parameter int DAS_FRAMES = 10,
  parameter int ARR_FRAMES = 2,
  parameter int CNT_W      = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic pressed,
  output logic fire,
  output logic press,
  output logic rel,
  output logic held
);
  import key_action_pkg::*;

  localparam logic [CNT_W-1:0] DAS_LD = CNT_W'(DAS_FRAMES - 1);
  localparam logic [CNT_W-1:0] ARR_LD = CNT_W'(ARR_FRAMES - 1);

  rpt_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fire_q, fire_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fire_q  <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fire_q  <= fire_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire_d  = 1'b0;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (pressed) begin
            fire_d  = 1'b1;
            press_d = 1'b1;
            if (REPEAT) begin
              state_d = DELAY;
              cnt_d   = DAS_LD;
            end else begin
              state_d = HELD;
            end
          end
        end
        DELAY, key_action_pkg::REPEAT: begin
          if (!pressed) begin
            rel_d   = 1'b1;
            state_d = IDLE;
          end else if (cnt_q == '0) begin
            fire_d  = 1'b1;
            state_d = key_action_pkg::REPEAT;
            cnt_d   = ARR_LD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        HELD: begin
          if (!pressed) begin
            rel_d   = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign fire  = fire_q;
  assign press = press_q;
  assign rel   = rel_q;
  assign held  = (state_q != IDLE);

endmodule

// File: rtl/key_action_ctrl.sv
// Maps packed HID keycode slots to per-action press/release/repeat
// pulses, advanced once per frame tick.
module key_action_ctrl
  import key_action_pkg::*;
#(
  parameter int                    NUM_SLOTS    = 8,
  parameter int                    NUM_ACTIONS  = 6,
  parameter logic [NUM_ACTIONS*8-1:0] ACTION_CODES =
    {KEY_P, KEY_Q, KEY_W, KEY_S, KEY_D, KEY_A},
  parameter logic [NUM_ACTIONS-1:0] REPEAT_MASK  = 6'b000111,
  parameter int                    DAS_FRAMES   = 10,
  parameter int                    ARR_FRAMES   = 2,
  parameter int                    CNT_W        = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic [NUM_SLOTS*8-1:0] keycodes,
  output logic [NUM_ACTIONS-1:0] action_fire,
  output logic [NUM_ACTIONS-1:0] action_press,
  output logic [NUM_ACTIONS-1:0] action_release,
  output logic [NUM_ACTIONS-1:0] action_held,
  output logic                   rollover_err
);

  logic [NUM_ACTIONS-1:0] pressed;
  logic                   roll;
  logic                   tick_ok;
  logic                   roll_q, roll_d;

  always_comb begin
    pressed = '0;
    roll    = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (keycodes[8*s +: 8] == KEY_ROLLOVER) roll = 1'b1;
    end
    for (int a = 0; a < NUM_ACTIONS; a++) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (ACTION_CODES[8*a +: 8] != 8'h00 &&
            keycodes[8*s +: 8] == ACTION_CODES[8*a +: 8])
          pressed[a] = 1'b1;
      end
    end
  end

  // A rollover frame freezes every FSM as if no tick arrived
  assign tick_ok = frame_tick & ~roll;
  assign roll_d  = frame_tick ? roll : roll_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) roll_q <= 1'b0;
    else       roll_q <= roll_d;
  end

  assign rollover_err = roll_q;

  for (genvar a = 0; a < NUM_ACTIONS; a++) begin : g_act
    key_repeat_fsm #(
      .REPEAT     (REPEAT_MASK[a]),
      .DAS_FRAMES (DAS_FRAMES),
      .ARR_FRAMES (ARR_FRAMES),
      .CNT_W      (CNT_W)
    ) u_fsm (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick_ok),
      .pressed (pressed[a]),
      .fire    (action_fire[a]),
      .press   (action_press[a]),
      .rel     (action_release[a]),
      .held    (action_held[a])
    );
  end

endmodule

// File: tb/tb_key_action_ctrl.sv
// Directed bench for key_action_ctrl: ticks every 4 clks,
// hand-computed expectations per tick.
module tb_key_action_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic [63:0] keycodes = '0;
  logic [5:0]  action_fire;
  logic [5:0]  action_press;
  logic [5:0]  action_release;
  logic [5:0]  action_held;
  logic        rollover_err;

  int n_checks = 0;
  int n_fails  = 0;

  key_action_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .frame_tick     (frame_tick),
    .keycodes       (keycodes),
    .action_fire    (action_fire),
    .action_press   (action_press),
    .action_release (action_release),
    .action_held    (action_held),
    .rollover_err   (rollover_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] kc(input int s, input logic [7:0] c);
    logic [63:0] v;
    v = '0;
    v[8*s +: 8] = c;
    return v;
  endfunction

  // One frame: tick with kc, check the cycle after, then idle 3 clks.
  task automatic frame(input string tag, input logic [63:0] k,
                       input logic [5:0] ef, input logic [5:0] ep,
                       input logic [5:0] er, input logic [5:0] eh,
                       input logic eroll);
    @(negedge clk);
    keycodes   = k;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check({tag, ".fire"}, 32'(action_fire), 32'(ef));
    check({tag, ".press"}, 32'(action_press), 32'(ep));
    check({tag, ".rel"}, 32'(action_release), 32'(er));
    check({tag, ".held"}, 32'(action_held), 32'(eh));
    check({tag, ".roll"}, 32'(rollover_err), 32'(eroll));
    @(negedge clk);
    check({tag, ".idle"},
          32'({action_fire, action_press, action_release}), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [5:0]  ef;
    logic [63:0] k;

    repeat (3) @(negedge clk);
    check("rst.fire", 32'(action_fire), 32'd0);
    check("rst.held", 32'(action_held), 32'd0);
    check("rst.roll", 32'(rollover_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: KEY_A auto-repeats after DAS then every ARR
    for (int t = 0; t < 20; t++) begin
      ef = (t == 0 || (t >= 10 && t % 2 == 0)) ? 6'b000001 : 6'b0;
      frame($sformatf("t1_%0d", t), kc(0, 8'h04), ef,
            (t == 0) ? 6'b000001 : 6'b0, 6'b0, 6'b000001, 1'b0);
    end
    frame("t1_rel", '0, 6'b0, 6'b0, 6'b000001, 6'b0, 1'b0);

    // 2: KEY_W is one-shot
    for (int t = 0; t < 20; t++) begin
      ef = (t == 0) ? 6'b001000 : 6'b0;
      frame($sformatf("t2_%0d", t), kc(0, 8'h1A), ef, ef,
            6'b0, 6'b001000, 1'b0);
    end
    frame("t2_rel", '0, 6'b0, 6'b0, 6'b001000, 6'b0, 1'b0);

    // 3: simultaneous presses, duplicate code across slots
    frame("t3_both", kc(0, 8'h04) | kc(5, 8'h07), 6'b000011,
          6'b000011, 6'b0, 6'b000011, 1'b0);
    frame("t3_rel", '0, 6'b0, 6'b0, 6'b000011, 6'b0, 1'b0);
    frame("t3_dup", kc(0, 8'h04) | kc(3, 8'h04), 6'b000001,
          6'b000001, 6'b0, 6'b000001, 1'b0);
    frame("t3_one", kc(3, 8'h04), 6'b0, 6'b0, 6'b0, 6'b000001, 1'b0);
    frame("t3_end", '0, 6'b0, 6'b0, 6'b000001, 6'b0, 1'b0);

    // 4: rollover frames 5..7 freeze KEY_D's DAS count
    for (int t = 0; t < 16; t++) begin
      k  = kc(2, 8'h07);
      if (t >= 5 && t <= 7) k = k | kc(7, 8'h01);
      ef = (t == 0 || t == 13 || t == 15) ? 6'b000010 : 6'b0;
      frame($sformatf("t4_%0d", t), k, ef,
            (t == 0) ? 6'b000010 : 6'b0, 6'b0, 6'b000010,
            (t >= 5 && t <= 7));
    end
    frame("t4_rel", '0, 6'b0, 6'b0, 6'b000010, 6'b0, 1'b0);

    // 5: reset mid-DAS, then a fresh press with DAS restarted
    for (int t = 0; t < 6; t++)
      frame($sformatf("t5_%0d", t), kc(1, 8'h16),
            (t == 0) ? 6'b000100 : 6'b0, (t == 0) ? 6'b000100 : 6'b0,
            6'b0, 6'b000100, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5_rst.held", 32'(action_held), 32'd0);
    check("t5_rst.pulse",
          32'({action_fire, action_press, action_release}), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t < 12; t++) begin
      ef = (t == 0 || t == 10) ? 6'b000100 : 6'b0;
      frame($sformatf("t5p_%0d", t), kc(1, 8'h16), ef,
            (t == 0) ? 6'b000100 : 6'b0, 6'b0, 6'b000100, 1'b0);
    end
    frame("t5_rel", '0, 6'b0, 6'b0, 6'b000100, 6'b0, 1'b0);

    // 6: keycode churn without ticks does nothing
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      keycodes = kc(c, (c % 2 == 0) ? 8'h04 : 8'h01) | kc(7 - c, 8'h13);
      @(negedge clk);
      check($sformatf("t6_%0d", c),
            32'({action_fire, action_press, action_release,
                 action_held, rollover_err}), 32'd0);
    end
    frame("t6_zero", '0, 6'b0, 6'b0, 6'b0, 6'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
